// File: rtl/biriscv_defs.sv
// Shared definitions for the fetch queue: instruction/PC widths and the
// packed layout of one queue entry.
package biriscv_defs;

  localparam int unsigned INST_W  = 32;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned PC_STEP = 4;

  // Packed entry layout, MSB first: instr, pc, pred, fault_fetch, fault_page
  typedef struct packed {
    logic [INST_W-1:0] instr;
    logic [PC_W-1:0]   pc;
    logic              pred;
    logic              fault_fetch;
    logic              fault_page;
  } fq_entry_t;

endpackage

// File: rtl/biriscv_fetch_queue_if.sv
// Fetch-side and decode-side signals of the fetch queue.
interface biriscv_fetch_queue_if #(
  parameter int unsigned FETCH_LANES = 2,
  parameter int unsigned OUT_LANES   = 2,
  parameter int unsigned DEPTH_W     = 3
) ();

  logic                      flush_i;
  logic                      in_valid_i;
  logic [32*FETCH_LANES-1:0] in_instr_i;
  logic [31:0]               in_pc_i;
  logic [FETCH_LANES-1:0]    in_mask_i;
  logic [FETCH_LANES-1:0]    in_pred_branch_i;
  logic                      in_fault_fetch_i;
  logic                      in_fault_page_i;
  logic                      in_accept_o;
  logic [OUT_LANES-1:0]      out_valid_o;
  logic [32*OUT_LANES-1:0]   out_instr_o;
  logic [32*OUT_LANES-1:0]   out_pc_o;
  logic [OUT_LANES-1:0]      out_pred_branch_o;
  logic [OUT_LANES-1:0]      out_fault_fetch_o;
  logic [OUT_LANES-1:0]      out_fault_page_o;
  logic [OUT_LANES-1:0]      out_accept_i;
  logic [DEPTH_W:0]          level_o;

  modport master (
    output flush_i, in_valid_i, in_instr_i, in_pc_i, in_mask_i,
           in_pred_branch_i, in_fault_fetch_i, in_fault_page_i, out_accept_i,
    input  in_accept_o, out_valid_o, out_instr_o, out_pc_o,
           out_pred_branch_o, out_fault_fetch_o, out_fault_page_o, level_o
  );

  modport slave (
    input  flush_i, in_valid_i, in_instr_i, in_pc_i, in_mask_i,
           in_pred_branch_i, in_fault_fetch_i, in_fault_page_i, out_accept_i,
    output in_accept_o, out_valid_o, out_instr_o, out_pc_o,
           out_pred_branch_o, out_fault_fetch_o, out_fault_page_o, level_o
  );

endinterface

// File: rtl/biriscv_fq_lane_count.sv
// Lane arithmetic for the fetch queue: push popcount, per-lane compaction
// offsets and the in-order pop count.
module biriscv_fq_lane_count #(
  parameter int unsigned FETCH_LANES = 2,
  parameter int unsigned OUT_LANES   = 2,
  parameter int unsigned CNT_W       = 4
) (
  input  logic [FETCH_LANES-1:0]       mask_i,
  input  logic [OUT_LANES-1:0]         take_i,
  output logic [CNT_W-1:0]             push_cnt_o,
  output logic [FETCH_LANES*CNT_W-1:0] offset_o,
  output logic [CNT_W-1:0]             pop_cnt_o
);

  logic [CNT_W-1:0] acc;
  logic             run;

  always_comb begin
    acc      = '0;
    offset_o = '0;
    for (int unsigned k = 0; k < FETCH_LANES; k++) begin
      offset_o[k*CNT_W +: CNT_W] = acc;
      if (mask_i[k]) acc = acc + CNT_W'(1);
    end
    push_cnt_o = acc;
  end

  // Stops at the first lane not taken so issue stays in order
  always_comb begin
    run       = 1'b1;
    pop_cnt_o = '0;
    for (int unsigned k = 0; k < OUT_LANES; k++) begin
      run = run & take_i[k];
      if (run) pop_cnt_o = pop_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: rtl/biriscv_fetch_queue.sv
// Instruction queue between fetch and the dual-issue decoder: compacts masked
// fetch bundles into a circular buffer and presents the oldest entries.
module biriscv_fetch_queue
  import biriscv_defs::*;
#(
  parameter int unsigned FETCH_LANES = 2,
  parameter int unsigned OUT_LANES   = 2,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned DEPTH_W     = 3
) (
  input logic                 clk,
  input logic                 rst,
  biriscv_fetch_queue_if.slave bus
);

  localparam int unsigned CNT_W = DEPTH_W + 1;

  logic [CNT_W-1:0]             count_q, count_d;
  logic [DEPTH_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [DEPTH_W-1:0]           wr_ptr_q, wr_ptr_d;
  fq_entry_t                    mem_q [DEPTH];

  logic                         accept;
  logic                         push_en;
  logic                         fault;
  logic [CNT_W-1:0]             free_slots;
  logic [CNT_W-1:0]             mask_cnt;
  logic [CNT_W-1:0]             pushed;
  logic [CNT_W-1:0]             popped;
  logic [FETCH_LANES*CNT_W-1:0] offsets;
  logic [OUT_LANES-1:0]         out_valid;

  fq_entry_t                    lane_ent  [FETCH_LANES];
  logic                         lane_we   [FETCH_LANES];
  logic [DEPTH_W-1:0]           lane_addr [FETCH_LANES];
  fq_entry_t                    out_ent   [OUT_LANES];

  biriscv_fq_lane_count #(
    .FETCH_LANES (FETCH_LANES),
    .OUT_LANES   (OUT_LANES),
    .CNT_W       (CNT_W)
  ) u_lane_count (
    .mask_i     (bus.in_mask_i),
    .take_i     (bus.out_accept_i & out_valid),
    .push_cnt_o (mask_cnt),
    .offset_o   (offsets),
    .pop_cnt_o  (popped)
  );

  // Space check uses start-of-cycle occupancy; same-cycle pops are not credited
  assign free_slots = CNT_W'(DEPTH) - count_q;
  assign accept     = !rst && !bus.flush_i && (free_slots >= CNT_W'(FETCH_LANES));
  assign push_en    = bus.in_valid_i && accept;
  assign fault      = bus.in_fault_fetch_i || bus.in_fault_page_i;

  always_comb begin
    pushed = '0;
    if (push_en) pushed = fault ? CNT_W'(1) : mask_cnt;
  end

  always_comb begin
    for (int unsigned k = 0; k < OUT_LANES; k++)
      out_valid[k] = (count_q > CNT_W'(k));
  end

  // A fault bundle reuses lane 0's write port to store its single entry
  always_comb begin
    for (int unsigned k = 0; k < FETCH_LANES; k++) begin
      lane_ent[k].instr       = bus.in_instr_i[32*k +: 32];
      lane_ent[k].pc          = bus.in_pc_i + PC_W'(PC_STEP * k);
      lane_ent[k].pred        = bus.in_pred_branch_i[k];
      lane_ent[k].fault_fetch = 1'b0;
      lane_ent[k].fault_page  = 1'b0;
      lane_we[k]              = push_en && !fault && bus.in_mask_i[k];
      lane_addr[k]            = wr_ptr_q + DEPTH_W'(offsets[k*CNT_W +: CNT_W]);
    end
    if (fault) begin
      lane_ent[0].instr       = '0;
      lane_ent[0].pc          = bus.in_pc_i;
      lane_ent[0].pred        = 1'b0;
      lane_ent[0].fault_fetch = bus.in_fault_fetch_i;
      lane_ent[0].fault_page  = bus.in_fault_page_i;
      lane_we[0]              = push_en;
      lane_addr[0]            = wr_ptr_q;
    end
  end

  always_comb begin
    count_d  = count_q + pushed - popped;
    rd_ptr_d = rd_ptr_q + DEPTH_W'(popped);
    wr_ptr_d = wr_ptr_q + DEPTH_W'(pushed);
    if (bus.flush_i) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int unsigned k = 0; k < FETCH_LANES; k++)
        if (lane_we[k]) mem_q[lane_addr[k]] <= lane_ent[k];
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < OUT_LANES; k++) begin
      out_ent[k]                    = mem_q[rd_ptr_q + DEPTH_W'(k)];
      bus.out_instr_o[32*k +: 32]   = out_ent[k].instr;
      bus.out_pc_o[32*k +: 32]      = out_ent[k].pc;
      bus.out_pred_branch_o[k]      = out_ent[k].pred;
      bus.out_fault_fetch_o[k]      = out_ent[k].fault_fetch;
      bus.out_fault_page_o[k]       = out_ent[k].fault_page;
    end
  end

  assign bus.out_valid_o = out_valid;
  assign bus.in_accept_o = accept;
  assign bus.level_o     = count_q;

endmodule

// File: tb/tb_biriscv_fetch_queue.sv
// Randomised and directed bench for biriscv_fetch_queue against a queue-based
// reference model.
module tb_biriscv_fetch_queue;

  localparam int unsigned FL    = 2;
  localparam int unsigned OL    = 2;
  localparam int unsigned DEPTH = 8;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    bit          pred;
    bit          ff;
    bit          fp;
  } ent_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  ent_t q[$];

  biriscv_fetch_queue_if #(.FETCH_LANES(FL), .OUT_LANES(OL), .DEPTH_W(3)) bus ();

  biriscv_fetch_queue #(
    .FETCH_LANES (FL),
    .OUT_LANES   (OL),
    .DEPTH       (DEPTH),
    .DEPTH_W     (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_accept();
    return !rst && !bus.flush_i && (DEPTH - q.size() >= FL);
  endfunction

  task automatic compare_outputs();
    check("level", 64'(bus.level_o), 64'(q.size()));
    check("in_accept", 64'(bus.in_accept_o), 64'(model_accept()));
    for (int k = 0; k < OL; k++) begin
      check("out_valid", 64'(bus.out_valid_o[k]), 64'(k < q.size()));
      if (k < q.size()) begin
        check("out_instr", 64'(bus.out_instr_o[32*k +: 32]), 64'(q[k].instr));
        check("out_pc", 64'(bus.out_pc_o[32*k +: 32]), 64'(q[k].pc));
        check("out_pred", 64'(bus.out_pred_branch_o[k]), 64'(q[k].pred));
        check("out_ffetch", 64'(bus.out_fault_fetch_o[k]), 64'(q[k].ff));
        check("out_fpage", 64'(bus.out_fault_page_o[k]), 64'(q[k].fp));
      end
    end
  endtask

  task automatic model_step();
    bit   acc;
    int   n;
    ent_t e;
    acc = model_accept();
    if (bus.flush_i) begin
      q.delete();
      return;
    end
    n = 0;
    while (n < OL && n < q.size() && bus.out_accept_i[n]) n++;
    repeat (n) void'(q.pop_front());
    if (bus.in_valid_i && acc) begin
      if (bus.in_fault_fetch_i || bus.in_fault_page_i) begin
        e.instr = '0; e.pc = bus.in_pc_i; e.pred = 0;
        e.ff = bus.in_fault_fetch_i; e.fp = bus.in_fault_page_i;
        q.push_back(e);
      end else begin
        for (int k = 0; k < FL; k++) begin
          if (bus.in_mask_i[k]) begin
            e.instr = bus.in_instr_i[32*k +: 32];
            e.pc    = bus.in_pc_i + 32'(4 * k);
            e.pred  = bus.in_pred_branch_i[k];
            e.ff = 0; e.fp = 0;
            q.push_back(e);
          end
        end
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    compare_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [1:0] mask, input logic [31:0] pc);
    bus.in_valid_i       = v;
    bus.in_mask_i        = mask;
    bus.in_pc_i          = pc;
    bus.in_instr_i       = {pc ^ 32'h5A5A_0001, pc ^ 32'hA5A5_0000};
    bus.in_pred_branch_i = pc[4:3];
    bus.in_fault_fetch_i = 1'b0;
    bus.in_fault_page_i  = 1'b0;
  endtask

  initial begin
    logic [31:0] pc;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.flush_i = 1'b0;
    bus.out_accept_i = '0;
    set_in(1'b0, 2'b00, 32'h0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_level", 64'(bus.level_o), 64'd0);
    check("rst_valid", 64'(bus.out_valid_o), 64'd0);
    check("rst_accept", 64'(bus.in_accept_o), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // full bundle at 0x8000_0000
    set_in(1'b1, 2'b11, 32'h8000_0000);
    cycle();
    set_in(1'b0, 2'b00, 32'h0);
    check("t1_level", 64'(bus.level_o), 64'd2);
    check("t1_pc1", 64'(bus.out_pc_o[63:32]), 64'h8000_0004);
    bus.out_accept_i = 2'b11;
    cycle();
    bus.out_accept_i = 2'b00;

    // single upper lane
    set_in(1'b1, 2'b10, 32'h100);
    cycle();
    set_in(1'b0, 2'b00, 32'h0);
    check("t2_level", 64'(bus.level_o), 64'd1);
    check("t2_pc0", 64'(bus.out_pc_o[31:0]), 64'h104);
    bus.out_accept_i = 2'b11;
    cycle();
    bus.out_accept_i = 2'b00;

    // fill to full with decode stalled
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 2'b11, 32'h2000 + 32'(8 * i));
      cycle();
    end
    check("full_level", 64'(bus.level_o), 64'd8);
    check("full_accept", 64'(bus.in_accept_o), 64'd0);
    bus.out_accept_i = 2'b11;
    cycle();
    set_in(1'b0, 2'b00, 32'h0);
    check("after_pop_accept", 64'(bus.in_accept_o), 64'd1);
    check("after_pop_level", 64'(bus.level_o), 64'd6);
    cycle();
    cycle();
    bus.out_accept_i = 2'b10;
    cycle();
    check("acc10_level", 64'(bus.level_o), 64'd2);
    bus.out_accept_i = 2'b01;
    cycle();
    check("acc01_level", 64'(bus.level_o), 64'd1);
    bus.out_accept_i = 2'b11;
    cycle();

    // sustained push/pop across the pointer wrap
    bus.out_accept_i = 2'b11;
    set_in(1'b1, 2'b01, 32'h3000);
    cycle();
    for (int i = 0; i < 12; i++) begin
      set_in(1'b1, 2'b11, 32'h3004 + 32'(8 * i));
      cycle();
    end
    set_in(1'b0, 2'b00, 32'h0);
    repeat (2) cycle();
    check("wrap_drain", 64'(bus.level_o), 64'd0);

    // flush with push and pop pending, then a fault bundle
    bus.out_accept_i = 2'b00;
    set_in(1'b1, 2'b11, 32'h4000); cycle();
    set_in(1'b1, 2'b11, 32'h4008); cycle();
    set_in(1'b1, 2'b01, 32'h4010); cycle();
    check("pre_flush_level", 64'(bus.level_o), 64'd5);
    bus.flush_i = 1'b1;
    bus.out_accept_i = 2'b11;
    set_in(1'b1, 2'b11, 32'h4018);
    cycle();
    bus.flush_i = 1'b0;
    bus.out_accept_i = 2'b00;
    check("flush_level", 64'(bus.level_o), 64'd0);
    check("flush_valid", 64'(bus.out_valid_o), 64'd0);
    set_in(1'b1, 2'b11, 32'h5000);
    bus.in_fault_page_i = 1'b1;
    cycle();
    set_in(1'b0, 2'b00, 32'h0);
    check("fault_level", 64'(bus.level_o), 64'd1);
    check("fault_page", 64'(bus.out_fault_page_o[0]), 64'd1);
    check("fault_instr", 64'(bus.out_instr_o[31:0]), 64'd0);
    bus.out_accept_i = 2'b11;
    cycle();

    // randomised traffic
    pc = 32'h1_0000;
    for (int i = 0; i < 600; i++) begin
      set_in(1'($urandom_range(0, 3) != 0), 2'($urandom), pc);
      bus.in_pred_branch_i = 2'($urandom);
      if ($urandom_range(0, 11) == 0) begin
        bus.in_fault_fetch_i = 1'($urandom);
        bus.in_fault_page_i  = !bus.in_fault_fetch_i || 1'($urandom);
      end
      bus.out_accept_i = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom);
      bus.flush_i      = ($urandom_range(0, 24) == 0);
      cycle();
      pc = pc + 32'd8;
    end
    bus.flush_i = 1'b0;

    // asynchronous reset mid-operation
    bus.out_accept_i = 2'b00;
    set_in(1'b1, 2'b11, 32'h6000); cycle();
    set_in(1'b1, 2'b11, 32'h6008); cycle();
    set_in(1'b0, 2'b00, 32'h0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_level", 64'(bus.level_o), 64'd0);
    check("async_rst_valid", 64'(bus.out_valid_o), 64'd0);
    check("async_rst_accept", 64'(bus.in_accept_o), 64'd0);
    q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    set_in(1'b1, 2'b11, 32'h7000); cycle();
    set_in(1'b0, 2'b00, 32'h0);
    bus.out_accept_i = 2'b11;
    cycle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
